// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 memory slice.
// Provides the default bus/address widths, the derived memory depth and the
// word/address types used by the RAM, its interface and its bench.
package sap1_pkg;

    localparam int SAP_DATA_W = 8;
    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DEPTH  = 1 << SAP_ADDR_W;

    typedef logic [SAP_DATA_W-1:0] sap_word_t;
    typedef logic [SAP_ADDR_W-1:0] sap_addr_t;

endpackage

// File: rtl/sap1_ram_if.sv
// Control, address, programming and monitor signals of the SAP-1 RAM.
// The shared data bus is a resolved inout net and is carried as a plain
// module port next to this interface, so its tristate resolves at the top.
//   nCe/nrd/nwr : active-low chip enable, read strobe, write strobe
//   addr        : bus-side word address
//   prog_*      : side programming port (prog_en selects it, prog_we strobes)
//   mon_q       : always mem[addr], for display LEDs
// master = controller/sequencer side, slave = memory side.
interface sap1_ram_if
    import sap1_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W
);

    logic              nCe;
    logic              nrd;
    logic              nwr;
    logic [ADDR_W-1:0] addr;
    logic              prog_en;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] mon_q;

    modport master (
        output nCe, nrd, nwr, addr,
        output prog_en, prog_we, prog_addr, prog_data,
        input  mon_q
    );

    modport slave (
        input  nCe, nrd, nwr, addr,
        input  prog_en, prog_we, prog_addr, prog_data,
        output mon_q
    );

endinterface

// File: rtl/sap1_ram_bus_tristate.sv
// Output-enable buffer onto a shared bus.
//   oe : 1 = drive d onto y, otherwise y is released (high-impedance)
//   d  : value to drive
//   y  : bus-side net
module bus_tristate #(
    parameter int W = 8
) (
    input  logic         oe,
    input  logic [W-1:0] d,
    output wire  [W-1:0] y
);

    assign y = oe ? d : {W{1'bz}};

endmodule

// File: rtl/sap1_ram.sv
// 16 x 8 flop-based read/write memory for the SAP-1 CPU.
//   CLK   : writes happen on the rising edge
//   nRst  : asynchronous active-low reset, clears every word to zero
//   bus   : control/address/programming/monitor signals (slave side)
//   data  : shared bidirectional system bus; driven only during a bus read,
//           sampled at the clock edge during a bus write
// Programming mode (prog_en=1) hands the array to the side port and makes the
// bus strobes inert. A read with nwr also low counts as a write, so the
// memory never drives the bus while the bus master is driving it.
module sap1_ram
    import sap1_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DEPTH  = SAP_DEPTH   // must equal 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              nRst,
    sap1_ram_if.slave         bus,
    inout  wire  [DATA_W-1:0] data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              rd_act_s;
    logic              wr_act_s;
    logic              pg_act_s;
    logic [DATA_W-1:0] rd_word_s;

    // Decode the access type and select the word presented on the bus/monitor.
    always_comb begin
        rd_act_s  = 1'b0;
        wr_act_s  = 1'b0;
        pg_act_s  = 1'b0;
        rd_word_s = mem_r[bus.addr];
        if (nRst) begin
            if (bus.prog_en) begin
                pg_act_s = bus.prog_we;
            end else begin
                // Write wins over read so both strobes low never drives the bus.
                rd_act_s = ~bus.nCe & ~bus.nrd & bus.nwr;
                wr_act_s = ~bus.nCe & ~bus.nwr;
            end
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
    end

    // Monitor output follows the addressed word without any strobe gating.
    always_comb begin
        bus.mon_q = rd_word_s;
    end

    // Memory array: async clear, then programming port or bus write per edge.
    always_ff @(posedge CLK or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (pg_act_s) begin
            mem_r[bus.prog_addr] <= bus.prog_data;
        end else if (wr_act_s) begin
            mem_r[bus.addr] <= data;
        end
    end

    bus_tristate #(
        .W (DATA_W)
    ) u_bus_tristate (
        .oe (rd_act_s),
        .d  (rd_word_s),
        .y  (data)
    );

endmodule

// File: tb/tb_sap1_ram.sv
// Self-checking bench for sap1_ram. The data bus carries a pull-up, so a
// released bus reads as all ones; contents at checked addresses are chosen
// to differ from 0xFF wherever a release is being observed.
module tb_sap1_ram;
    import sap1_pkg::*;

    logic      CLK = 1'b0;
    logic      nRst;
    wire [7:0] data;
    logic      drv_en;
    logic [7:0] drv_val;

    sap_word_t model [16];
    int        n_tests = 0;
    int        n_fail  = 0;

    assign data = drv_en ? drv_val : 8'hzz;
    pullup pu_data (data);

    sap1_ram_if bus_if ();

    sap1_ram dut (
        .CLK  (CLK),
        .nRst (nRst),
        .bus  (bus_if.slave),
        .data (data)
    );

    always #5 CLK = ~CLK;

    task automatic set_idle();
        bus_if.nCe       = 1'b1;
        bus_if.nrd       = 1'b1;
        bus_if.nwr       = 1'b1;
        bus_if.prog_en   = 1'b0;
        bus_if.prog_we   = 1'b0;
        bus_if.prog_addr = 4'h0;
        bus_if.prog_data = 8'h00;
        drv_en           = 1'b0;
        drv_val          = 8'h00;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] v);
        @(negedge CLK);
        bus_if.nCe  = 1'b0;
        bus_if.nrd  = 1'b1;
        bus_if.nwr  = 1'b0;
        bus_if.addr = a;
        drv_en      = 1'b1;
        drv_val     = v;
        @(posedge CLK);
        #1;
        model[a] = v;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        nRst        = 1'b0;
        bus_if.addr = 4'h2;
        #2;
        bus_if.nCe = 1'b0;
        bus_if.nrd = 1'b0;
        #2;
        n_tests++;
        if (bus_if.mon_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mon: got %h want %h", bus_if.mon_q, 8'h00);
        end
        n_tests++;
        if (data !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_bus_release: got %h want %h", data, 8'hFF);
        end
        // Writes attempted while held in reset must be ignored.
        bus_if.nrd = 1'b1;
        bus_if.nwr = 1'b0;
        drv_en     = 1'b1;
        drv_val    = 8'h5A;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        set_idle();
        model_clear();
        @(negedge CLK);
        nRst        = 1'b1;
        bus_if.nCe  = 1'b0;
        bus_if.nrd  = 1'b0;
        bus_if.addr = 4'h2;
        #2;
        n_tests++;
        if (data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_read: got %h want %h", data, 8'h00);
        end
        n_tests++;
        if (bus_if.mon_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_read_mon: got %h want %h", bus_if.mon_q, 8'h00);
        end
        bus_if.nCe = 1'b1;
        #2;
        n_tests++;
        if (data !== 8'hFF) begin
            n_fail++;
            $display("FAIL chip_disable_release: got %h want %h", data, 8'hFF);
        end
        set_idle();
    endtask

    task automatic test_write_read();
        bus_write(4'h5, 8'hDC);
        @(negedge CLK);
        bus_if.nCe  = 1'b0;
        bus_if.nrd  = 1'b0;
        bus_if.addr = 4'h5;
        #2;
        n_tests++;
        if (data !== model[5]) begin
            n_fail++;
            $display("FAIL write_read_bus: got %h want %h", data, model[5]);
        end
        n_tests++;
        if (bus_if.mon_q !== 8'hDC) begin
            n_fail++;
            $display("FAIL write_read_mon: got %h want %h", bus_if.mon_q, 8'hDC);
        end
        set_idle();
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            bus_write(4'(i), 8'(i * 17));
        end
        @(negedge CLK);
        bus_if.nCe = 1'b0;
        bus_if.nrd = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_if.addr = 4'(i);
            #1;
            n_tests++;
            if (data !== 8'(i * 17)) begin
                n_fail++;
                $display("FAIL sweep_bus[%0d]: got %h want %h", i, data, 8'(i * 17));
            end
            n_tests++;
            if (bus_if.mon_q !== model[i]) begin
                n_fail++;
                $display("FAIL sweep_mon[%0d]: got %h want %h", i, bus_if.mon_q, model[i]);
            end
        end
        set_idle();
    endtask

    task automatic test_contention();
        // mem[3] holds 0x33 from the sweep, so a drive would not read as 0xFF.
        @(negedge CLK);
        bus_if.nCe  = 1'b0;
        bus_if.nrd  = 1'b0;
        bus_if.nwr  = 1'b0;
        bus_if.addr = 4'h3;
        #2;
        n_tests++;
        if (data !== 8'hFF) begin
            n_fail++;
            $display("FAIL both_strobes_no_drive: got %h want %h", data, 8'hFF);
        end
        drv_en  = 1'b1;
        drv_val = 8'hA5;
        @(posedge CLK);
        #1;
        model[3] = 8'hA5;
        n_tests++;
        if (bus_if.mon_q !== 8'hA5) begin
            n_fail++;
            $display("FAIL both_strobes_write: got %h want %h", bus_if.mon_q, 8'hA5);
        end
        set_idle();
        @(negedge CLK);
        bus_if.nCe  = 1'b1;
        bus_if.nwr  = 1'b0;
        bus_if.addr = 4'h3;
        drv_en      = 1'b1;
        drv_val     = 8'h12;
        @(posedge CLK);
        #1;
        n_tests++;
        if (bus_if.mon_q !== model[3]) begin
            n_fail++;
            $display("FAIL nce_blocks_write: got %h want %h", bus_if.mon_q, model[3]);
        end
        set_idle();
    endtask

    task automatic test_prog();
        @(negedge CLK);
        bus_if.prog_en   = 1'b1;
        bus_if.prog_we   = 1'b1;
        bus_if.prog_addr = 4'h9;
        bus_if.prog_data = 8'h3C;
        bus_if.nCe       = 1'b0;
        bus_if.nrd       = 1'b0;
        bus_if.addr      = 4'h9;
        #2;
        n_tests++;
        if (data !== 8'hFF) begin
            n_fail++;
            $display("FAIL prog_bus_release: got %h want %h", data, 8'hFF);
        end
        n_tests++;
        if (bus_if.mon_q !== 8'h99) begin
            n_fail++;
            $display("FAIL prog_mon_before_edge: got %h want %h", bus_if.mon_q, 8'h99);
        end
        @(posedge CLK);
        #1;
        model[9] = 8'h3C;
        n_tests++;
        if (bus_if.mon_q !== 8'h3C) begin
            n_fail++;
            $display("FAIL prog_write: got %h want %h", bus_if.mon_q, 8'h3C);
        end
        // Bus write strobe must be ignored while programming mode holds the array.
        bus_if.prog_we = 1'b0;
        bus_if.nrd     = 1'b1;
        bus_if.nwr     = 1'b0;
        drv_en         = 1'b1;
        drv_val        = 8'h00;
        @(posedge CLK);
        #1;
        n_tests++;
        if (bus_if.mon_q !== model[9]) begin
            n_fail++;
            $display("FAIL prog_blocks_bus_write: got %h want %h", bus_if.mon_q, model[9]);
        end
        set_idle();
        bus_if.nCe  = 1'b0;
        bus_if.nrd  = 1'b0;
        bus_if.addr = 4'h9;
        #2;
        n_tests++;
        if (data !== 8'h3C) begin
            n_fail++;
            $display("FAIL prog_readback: got %h want %h", data, 8'h3C);
        end
        set_idle();
    endtask

    task automatic test_random();
        logic rd_cond;
        logic wr_cond;
        logic [7:0] exp_bus;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            bus_if.prog_en   = ($urandom_range(0, 3) == 0);
            bus_if.prog_we   = 1'($urandom_range(0, 1));
            bus_if.prog_addr = 4'($urandom_range(0, 15));
            bus_if.prog_data = 8'($urandom_range(0, 254));
            bus_if.nCe       = ($urandom_range(0, 4) == 0);
            bus_if.nrd       = 1'($urandom_range(0, 1));
            bus_if.nwr       = 1'($urandom_range(0, 1));
            bus_if.addr      = 4'($urandom_range(0, 15));
            drv_val          = 8'($urandom_range(0, 254));
            rd_cond = !bus_if.prog_en && !bus_if.nCe && !bus_if.nrd && bus_if.nwr;
            wr_cond = !bus_if.prog_en && !bus_if.nCe && !bus_if.nwr;
            drv_en  = wr_cond;
            exp_bus = rd_cond ? model[bus_if.addr] : (wr_cond ? drv_val : 8'hFF);
            #2;
            n_tests++;
            if (data !== exp_bus) begin
                n_fail++;
                $display("FAIL random_bus[%0d]: got %h want %h", n, data, exp_bus);
            end
            n_tests++;
            if (bus_if.mon_q !== model[bus_if.addr]) begin
                n_fail++;
                $display("FAIL random_mon[%0d]: got %h want %h", n, bus_if.mon_q, model[bus_if.addr]);
            end
            @(posedge CLK);
            if (bus_if.prog_en && bus_if.prog_we) model[bus_if.prog_addr] = bus_if.prog_data;
            else if (wr_cond) model[bus_if.addr] = drv_val;
        end
        #1;
        set_idle();
    endtask

    task automatic test_async_reset();
        set_idle();
        bus_write(4'h1, 8'h77);
        @(negedge CLK);
        bus_if.addr = 4'h1;
        #1;
        n_tests++;
        if (bus_if.mon_q !== 8'h77) begin
            n_fail++;
            $display("FAIL async_pre_reset: got %h want %h", bus_if.mon_q, 8'h77);
        end
        nRst = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (bus_if.mon_q !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h want %h", bus_if.mon_q, 8'h00);
        end
        @(posedge CLK);
        @(negedge CLK);
        nRst       = 1'b1;
        bus_if.nCe = 1'b0;
        bus_if.nrd = 1'b0;
        #2;
        n_tests++;
        if (data !== model[1]) begin
            n_fail++;
            $display("FAIL async_reset_readback: got %h want %h", data, model[1]);
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_sweep();
        test_contention();
        test_prog();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
